addr_mode_sequencer: RTL and testbench
======================================

// Module: addr_mode_sequencer
// PURPOSE
//   Drives the addressing-mode flag generators. Latches each fetched opcode,
//   decodes its 6502 addressing mode and steps the 4-bit state through
//   FETCH -> A0..An -> E0..Em -> FETCH. Returns the low-byte carry to the
//   (zp),Y generator as carry_to_high_op. Sits between the data bus and the
//   per-mode flag generators / execute decoders in the control unit.
// PARAMETERS
//   NOP_OPCODE  8'hEA  opcode_q value after reset
// PORTS
//   clk                input   1  system clock, all state on rising edge
//   rst                input   1  synchronous active-high reset
//   ready              input   1  1 = advance this cycle; 0 = hold every register
//   data_in            input   8  data bus; holds the opcode during FETCH
//   exec_cycles        input   2  execute length from execute decoder; m = value, E0..Em
//   carry_from_low_op  input   1  ALU carry of the low-byte add (valid in A1)
//   state              output  4  current state code: FETCH, A0-A3, E0-E3 (shared package)
//   mode               output  4  decoded mode: IMP=0 IMM=1 ZPG=2 ZPX=3 ZPY=4 ABS=5 ABX=6 ABY=7 INX=8 INY=9
//   opcode_q           output  8  latched opcode of the current instruction
//   opcode_load        output  1  high in FETCH: opcode is captured on this edge if ready
//   carry_to_high_op   output  1  registered carry, nonzero only in A2 of INY
//   instr_done         output  1  high during the last E state
// BEHAVIOUR
// - Reset (clk edge with rst=1): state=FETCH, opcode_q=NOP_OPCODE, carry reg=0,
//   E-count reg=0. Outputs then read mode=IMP, instr_done=0, carry_to_high_op=0.
//   rst overrides ready. rst in mid-instruction aborts the instruction; the next
//   cycle is FETCH.
// - ready=0: state, opcode_q, carry reg and E-count all hold. Outputs stay
//   consistent with the held state.
// - mode is combinational from opcode_q. Decode by cc=op[1:0], bbb=op[4:2],
//   aaa=op[7:5]:
//   cc=01 bbb: 000 INX, 001 ZPG, 010 IMM, 011 ABS, 100 INY, 101 ZPX, 110 ABY, 111 ABX.
//   cc=00/10 bbb: 000 IMM if (cc=10 or aaa[2]=1), else IMP except 8'h20=ABS;
//   001 ZPG; 010 IMP; 011 ABS; 100 IMP; 110 IMP;
//   101 ZPX, but ZPY when cc=10 and aaa in {100,101};
//   111 ABX, but ABY when cc=10 and aaa=101.
//   cc=11: IMP.
// - A-state count by mode: IMP/IMM 0; ZPG 1; ZPX/ZPY/ABS 2; ABX/ABY 3; INX/INY 4.
// - Transitions (each on a clock edge with ready=1):
//   - FETCH: opcode_q<=data_in. Next state is A0, or E0 if the new opcode's
//     count is 0. Next-state decode uses data_in, not the stale opcode_q.
//   - Ak goes to A(k+1) if k+1 < count, else to E0.
//   - E0: capture exec_cycles into the E-count reg.
//   - Ek goes to E(k+1) while k < E-count, else to FETCH. Use exec_cycles
//     directly when in E0.
// - instr_done=1 when the state is Ek with k equal to the E-count (exec_cycles
//   in E0). Exactly one cycle per instruction, or longer if ready stalls it.
// - Carry: on the edge leaving A1 with mode=INY, carry reg<=carry_from_low_op.
//   carry_to_high_op = carry reg & (state==A2) & (mode==INY). Carry reg clears
//   in FETCH.
// - Total cycles per instruction (ready=1) = 1 + A-count + exec_cycles + 1.
// - No illegal states are reachable. Any unused state code goes to FETCH on
//   the next edge.
// TESTING
//   1. rst=1 for 2 cycles -> state=FETCH, opcode_q=8'hEA, mode=0, instr_done=0,
//      carry_to_high_op=0.
//   2. data_in=8'hA5, exec_cycles=0 -> FETCH,A0,E0,FETCH; mode=2;
//      instr_done=1 only in E0.
//   3. data_in=8'hB1, carry_from_low_op=1 in A1 -> FETCH,A0,A1,A2,A3,E0;
//      carry_to_high_op=1 only in A2. Repeat with carry=0 -> carry_to_high_op
//      stays 0.
//   4. data_in=8'hBD, ready=0 for 3 cycles during A1 -> A1 lasts 4 cycles,
//      then A2, E0. opcode_q stays 8'hBD.
//   5. Decode sweep: 8'hEA->IMP, directly FETCH->E0; 8'hA2->IMM; 8'hB6->ZPY;
//      8'hBE->ABY; 8'h20->ABS; 8'hA1->INX. exec_cycles=3 -> E0..E3, then FETCH.
//   6. rst=1 during A2 of 8'hB1 with carry reg=1 -> next cycle FETCH,
//      carry_to_high_op=0, opcode_q=8'hEA.

Source files
------------

// File: rtl/addr_mode_sequencer.sv
// rtl/addr_mode_sequencer.sv - 6502 addressing-mode decode and FETCH/A/E state sequencer
// State codes: FETCH=4'h0, A0..A3=4'h4..4'h7, E0..E3=4'h8..4'hB.
module addr_mode_sequencer #(
   parameter logic [7:0] NOP_OPCODE = 8'hEA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ready,
   input  logic [7:0] data_in,
   input  logic [1:0] exec_cycles,
   input  logic       carry_from_low_op,
   output logic [3:0] state,
   output logic [3:0] mode,
   output logic [7:0] opcode_q,
   output logic       opcode_load,
   output logic       carry_to_high_op,
   output logic       instr_done
);

   typedef enum logic [3:0] {
      S_FETCH = 4'h0,
      S_A0    = 4'h4,
      S_A1    = 4'h5,
      S_A2    = 4'h6,
      S_A3    = 4'h7,
      S_E0    = 4'h8,
      S_E1    = 4'h9,
      S_E2    = 4'hA,
      S_E3    = 4'hB
   } state_t;

   localparam logic [3:0] M_IMP = 4'd0;
   localparam logic [3:0] M_IMM = 4'd1;
   localparam logic [3:0] M_ZPG = 4'd2;
   localparam logic [3:0] M_ZPX = 4'd3;
   localparam logic [3:0] M_ZPY = 4'd4;
   localparam logic [3:0] M_ABS = 4'd5;
   localparam logic [3:0] M_ABX = 4'd6;
   localparam logic [3:0] M_ABY = 4'd7;
   localparam logic [3:0] M_INX = 4'd8;
   localparam logic [3:0] M_INY = 4'd9;

   state_t     state_q;
   logic       carry_q;
   logic [1:0] e_cnt_q;
   logic [2:0] a_cnt;
   logic [2:0] a_cnt_next_op;
   logic [1:0] e_last;

   function automatic logic [3:0] decode_mode(input logic [7:0] op);
      logic [1:0] cc;
      logic [2:0] bbb;
      logic [2:0] aaa;
      logic [3:0] m;
      cc  = op[1:0];
      bbb = op[4:2];
      aaa = op[7:5];
      m   = M_IMP;
      if (cc == 2'b01) begin
         case (bbb)
            3'b000:  m = M_INX;
            3'b001:  m = M_ZPG;
            3'b010:  m = M_IMM;
            3'b011:  m = M_ABS;
            3'b100:  m = M_INY;
            3'b101:  m = M_ZPX;
            3'b110:  m = M_ABY;
            default: m = M_ABX;
         endcase
      end else if (cc != 2'b11) begin
         case (bbb)
            3'b000: begin
               if (cc == 2'b10 || aaa[2])
                  m = M_IMM;
               else if (op == 8'h20)
                  m = M_ABS;
               else
                  m = M_IMP;
            end
            3'b001:  m = M_ZPG;
            3'b011:  m = M_ABS;
            // LDX/STX zero-page forms index by Y instead of X
            3'b101:  m = (cc == 2'b10 && (aaa == 3'b100 || aaa == 3'b101)) ? M_ZPY : M_ZPX;
            3'b111:  m = (cc == 2'b10 && aaa == 3'b101) ? M_ABY : M_ABX;
            default: m = M_IMP;
         endcase
      end
      return m;
   endfunction

   function automatic logic [2:0] addr_count(input logic [3:0] m);
      logic [2:0] n;
      case (m)
         M_ZPG:               n = 3'd1;
         M_ZPX, M_ZPY, M_ABS: n = 3'd2;
         M_ABX, M_ABY:        n = 3'd3;
         M_INX, M_INY:        n = 3'd4;
         default:             n = 3'd0;
      endcase
      return n;
   endfunction

   assign mode          = decode_mode(opcode_q);
   assign a_cnt         = addr_count(mode);
   assign a_cnt_next_op = addr_count(decode_mode(data_in));
   assign e_last        = (state_q == S_E0) ? exec_cycles : e_cnt_q;

   assign state            = state_q;
   assign opcode_load      = (state_q == S_FETCH);
   assign carry_to_high_op = carry_q & (state_q == S_A2) & (mode == M_INY);
   assign instr_done       = (state_q[3:2] == 2'b10) && (state_q[1:0] == e_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         opcode_q <= NOP_OPCODE;
         carry_q  <= 1'b0;
         e_cnt_q  <= 2'd0;
      end else if (ready) begin
         case (state_q)
            S_FETCH: begin
               opcode_q <= data_in;
               carry_q  <= 1'b0;
               state_q  <= (a_cnt_next_op == 3'd0) ? S_E0 : S_A0;
            end
            S_A0, S_A1, S_A2, S_A3: begin
               if (state_q == S_A1 && mode == M_INY)
                  carry_q <= carry_from_low_op;
               if (({1'b0, state_q[1:0]} + 3'd1) < a_cnt)
                  state_q <= state_t'({2'b01, state_q[1:0] + 2'd1});
               else
                  state_q <= S_E0;
            end
            S_E0: begin
               e_cnt_q <= exec_cycles;
               state_q <= (exec_cycles != 2'd0) ? S_E1 : S_FETCH;
            end
            S_E1, S_E2, S_E3: begin
               if (state_q[1:0] < e_cnt_q)
                  state_q <= state_t'({2'b10, state_q[1:0] + 2'd1});
               else
                  state_q <= S_FETCH;
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// tb/tb_addr_mode_sequencer.sv - directed self-checking bench for addr_mode_sequencer
module tb_addr_mode_sequencer;

   localparam logic [3:0] FETCH = 4'h0;
   localparam logic [3:0] A0 = 4'h4, A1 = 4'h5, A2 = 4'h6, A3 = 4'h7;
   localparam logic [3:0] E0 = 4'h8, E1 = 4'h9, E2 = 4'hA, E3 = 4'hB;

   logic       clk = 1'b0;
   logic       rst;
   logic       ready;
   logic [7:0] data_in;
   logic [1:0] exec_cycles;
   logic       carry_from_low_op;
   logic [3:0] state;
   logic [3:0] mode;
   logic [7:0] opcode_q;
   logic       opcode_load;
   logic       carry_to_high_op;
   logic       instr_done;

   int compared   = 0;
   int mismatched = 0;

   addr_mode_sequencer dut (
      .clk               (clk),
      .rst               (rst),
      .ready             (ready),
      .data_in           (data_in),
      .exec_cycles       (exec_cycles),
      .carry_from_low_op (carry_from_low_op),
      .state             (state),
      .mode              (mode),
      .opcode_q          (opcode_q),
      .opcode_load       (opcode_load),
      .carry_to_high_op  (carry_to_high_op),
      .instr_done        (instr_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance one edge, then check state and instr_done.
   task automatic step_chk(input string tag, input logic [3:0] st, input logic done);
      step();
      chk({tag, ".state"}, {4'h0, state}, {4'h0, st});
      chk({tag, ".done"}, {7'h0, instr_done}, {7'h0, done});
   endtask

   initial begin
      rst = 1'b1; ready = 1'b1; data_in = 8'h00; exec_cycles = 2'd0; carry_from_low_op = 1'b0;

      // 1. reset
      step(); step();
      chk("rst.state", {4'h0, state}, {4'h0, FETCH});
      chk("rst.opcode", opcode_q, 8'hEA);
      chk("rst.mode", {4'h0, mode}, 8'h00);
      chk("rst.done", {7'h0, instr_done}, 8'h00);
      chk("rst.carry", {7'h0, carry_to_high_op}, 8'h00);
      chk("rst.load", {7'h0, opcode_load}, 8'h01);

      // 2. LDA zp
      rst = 1'b0; data_in = 8'hA5;
      step_chk("a5.0", A0, 1'b0);
      chk("a5.mode", {4'h0, mode}, 8'h02);
      chk("a5.opcode", opcode_q, 8'hA5);
      chk("a5.load", {7'h0, opcode_load}, 8'h00);
      step_chk("a5.1", E0, 1'b1);
      step_chk("a5.2", FETCH, 1'b0);

      // 3. LDA (zp),Y with low-byte carry set, then clear
      data_in = 8'hB1;
      step_chk("b1c.0", A0, 1'b0);
      chk("b1c.mode", {4'h0, mode}, 8'h09);
      step_chk("b1c.1", A1, 1'b0);
      chk("b1c.a1carry", {7'h0, carry_to_high_op}, 8'h00);
      carry_from_low_op = 1'b1;
      step_chk("b1c.2", A2, 1'b0);
      chk("b1c.a2carry", {7'h0, carry_to_high_op}, 8'h01);
      carry_from_low_op = 1'b0;
      step_chk("b1c.3", A3, 1'b0);
      chk("b1c.a3carry", {7'h0, carry_to_high_op}, 8'h00);
      step_chk("b1c.4", E0, 1'b1);
      step_chk("b1c.5", FETCH, 1'b0);

      data_in = 8'hB1;
      step_chk("b1n.0", A0, 1'b0);
      step_chk("b1n.1", A1, 1'b0);
      step_chk("b1n.2", A2, 1'b0);
      chk("b1n.a2carry", {7'h0, carry_to_high_op}, 8'h00);
      step_chk("b1n.3", A3, 1'b0);
      step_chk("b1n.4", E0, 1'b1);
      step_chk("b1n.5", FETCH, 1'b0);

      // 4. LDA abs,X with a 3-cycle stall in A1
      data_in = 8'hBD;
      step_chk("bd.0", A0, 1'b0);
      chk("bd.mode", {4'h0, mode}, 8'h06);
      data_in = 8'h00;
      step_chk("bd.1", A1, 1'b0);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_chk("bd.stall", A1, 1'b0);
         chk("bd.stall.opcode", opcode_q, 8'hBD);
      end
      ready = 1'b1;
      step_chk("bd.2", A2, 1'b0);
      step_chk("bd.3", E0, 1'b1);
      step_chk("bd.4", FETCH, 1'b0);
      chk("bd.opcode", opcode_q, 8'hBD);

      // 5. decode sweep
      data_in = 8'hEA;
      step_chk("ea.0", E0, 1'b1);
      chk("ea.mode", {4'h0, mode}, 8'h00);
      step_chk("ea.1", FETCH, 1'b0);

      data_in = 8'hA2;
      step_chk("a2.0", E0, 1'b1);
      chk("a2.mode", {4'h0, mode}, 8'h01);
      step_chk("a2.1", FETCH, 1'b0);

      data_in = 8'hB6;
      step_chk("b6.0", A0, 1'b0);
      chk("b6.mode", {4'h0, mode}, 8'h04);
      step_chk("b6.1", A1, 1'b0);
      step_chk("b6.2", E0, 1'b1);
      step_chk("b6.3", FETCH, 1'b0);

      data_in = 8'hBE;
      step_chk("be.0", A0, 1'b0);
      chk("be.mode", {4'h0, mode}, 8'h07);
      step_chk("be.1", A1, 1'b0);
      step_chk("be.2", A2, 1'b0);
      step_chk("be.3", E0, 1'b1);
      step_chk("be.4", FETCH, 1'b0);

      data_in = 8'h20;
      step_chk("20.0", A0, 1'b0);
      chk("20.mode", {4'h0, mode}, 8'h05);
      step_chk("20.1", A1, 1'b0);
      step_chk("20.2", E0, 1'b1);
      step_chk("20.3", FETCH, 1'b0);

      // INX with a 3-cycle execute; exec_cycles changes after E0 and must be ignored
      data_in = 8'hA1; exec_cycles = 2'd3;
      step_chk("a1.0", A0, 1'b0);
      chk("a1.mode", {4'h0, mode}, 8'h08);
      step_chk("a1.1", A1, 1'b0);
      step_chk("a1.2", A2, 1'b0);
      step_chk("a1.3", A3, 1'b0);
      step_chk("a1.4", E0, 1'b0);
      step_chk("a1.5", E1, 1'b0);
      exec_cycles = 2'd0;
      step_chk("a1.6", E2, 1'b0);
      step_chk("a1.7", E3, 1'b1);
      step_chk("a1.8", FETCH, 1'b0);

      // 6. reset aborts INY in A2 with carry reg set
      data_in = 8'hB1;
      step_chk("b1r.0", A0, 1'b0);
      step_chk("b1r.1", A1, 1'b0);
      carry_from_low_op = 1'b1;
      step_chk("b1r.2", A2, 1'b0);
      chk("b1r.a2carry", {7'h0, carry_to_high_op}, 8'h01);
      rst = 1'b1;
      step_chk("b1r.rst", FETCH, 1'b0);
      chk("b1r.carry", {7'h0, carry_to_high_op}, 8'h00);
      chk("b1r.opcode", opcode_q, 8'hEA);
      chk("b1r.mode", {4'h0, mode}, 8'h00);
      rst = 1'b0; carry_from_low_op = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
